// File: rtl/tl_chk_pkg.sv
// Shared definitions for the TileLink-UL in-flight check generator.
// Holds the A/D opcode encodings, the per-source table entry layout and
// helpers that turn an opcode/size pair into a burst length and an
// expected response opcode.
package tl_chk_pkg;

    // Width of the size field stored in each table entry
    localparam int SIZE_W = 4;

    localparam logic [2:0] A_PUTFULL       = 3'd0;
    localparam logic [2:0] A_PUTPARTIAL    = 3'd1;
    localparam logic [2:0] A_GET           = 3'd4;
    localparam logic [2:0] D_ACCESSACK     = 3'd0;
    localparam logic [2:0] D_ACCESSACKDATA = 3'd1;
    // No legal D opcode uses this value, so an entry holding it always mismatches
    localparam logic [2:0] OP_NEVER        = 3'd7;

    typedef struct packed {
        logic              valid;
        logic [2:0]        exp_op;
        logic [SIZE_W-1:0] size;
    } entry_t;

    // log2 of the number of beats in a burst. Only writes on A and
    // AccessAckData on D carry data over several beats; the result
    // saturates at max_log_beats.
    function automatic int beats_log2(input logic is_d, input logic [2:0] opcode,
                                      input int size, input int log_beat_bytes,
                                      input int max_log_beats);
        logic multi;
        multi = is_d ? (opcode == D_ACCESSACKDATA)
                     : (opcode == A_PUTFULL || opcode == A_PUTPARTIAL);
        if (!multi || size <= log_beat_bytes) begin
            return 0;
        end
        if (size - log_beat_bytes > max_log_beats) begin
            return max_log_beats;
        end
        return size - log_beat_bytes;
    endfunction

    // Response opcode a request is expected to receive
    function automatic logic [2:0] exp_op_for(input logic [2:0] a_opcode);
        case (a_opcode)
            A_GET:                   return D_ACCESSACKDATA;
            A_PUTFULL, A_PUTPARTIAL: return D_ACCESSACK;
            default:                 return OP_NEVER;
        endcase
    endfunction

endpackage

// File: rtl/tl_inflight_check_gen_beat_counter.sv
// Beat counter for one snooped TileLink channel.
// Ports: clock/reset_n, fire (beat accepted this cycle), opcode and size
// of the current beat; first = this beat opens a burst, last = this beat
// closes it. The counter wraps to zero on the last beat of a burst.
module tl_beat_counter
    import tl_chk_pkg::*;
#(
    parameter bit IS_D           = 1'b0,
    parameter int SIZE_BITS      = 4,
    parameter int LOG_BEAT_BYTES = 3,
    parameter int MAX_LOG_BEATS  = 3
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 fire,
    input  logic [2:0]           opcode,
    input  logic [SIZE_BITS-1:0] size,
    output logic                 first,
    output logic                 last
);

    localparam int CW = MAX_LOG_BEATS;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] beats_m1;
    int            lg;

    // Burst length comes from the beat currently on the bus; TileLink keeps
    // opcode and size stable across a burst so any beat gives the same answer.
    always_comb begin
        lg       = beats_log2(IS_D, opcode, int'(size), LOG_BEAT_BYTES, MAX_LOG_BEATS);
        beats_m1 = CW'((1 << lg) - 1);
        first    = (cnt_q == '0);
        last     = (cnt_q == beats_m1);
        cnt_d    = cnt_q;
        if (fire) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    // Beat position register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tl_inflight_check_gen.sv
// Passive TileLink-UL A/D monitor that tracks in-flight requests per source
// and, one cycle after each completed D response, presents a check tuple
// (idle, waive, expected, actual) for a downstream equality checker.
// Ports: clock, reset_n (async active-low); snooped A channel (valid, ready,
// opcode, size, source); snooped D channel (valid, ready, opcode, size,
// source, denied); chk_idle/chk_waive/chk_expect/chk_actual check tuple;
// err_source_reuse pulse; inflight_count of valid table entries.
module tl_inflight_check_gen
    import tl_chk_pkg::*;
#(
    parameter int SOURCE_BITS    = 4,
    parameter int SIZE_BITS      = SIZE_W,
    parameter int LOG_BEAT_BYTES = 3,
    parameter int MAX_LOG_BEATS  = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [SIZE_BITS-1:0]   a_size,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [SIZE_BITS-1:0]   d_size,
    input  logic [SOURCE_BITS-1:0] d_source,
    input  logic                   d_denied,
    output logic                   chk_idle,
    output logic                   chk_waive,
    output logic [3+SIZE_BITS:0]   chk_expect,
    output logic [3+SIZE_BITS:0]   chk_actual,
    output logic                   err_source_reuse,
    output logic [SOURCE_BITS:0]   inflight_count
);

    localparam int DEPTH = 1 << SOURCE_BITS;

    logic a_fire;
    logic d_fire;
    logic a_first;
    logic a_last;
    logic d_first;
    logic d_last;
    logic unused_beat_flags;

    entry_t table_q [DEPTH];
    entry_t table_d [DEPTH];
    entry_t d_ent;

    logic                 chk_idle_q, chk_idle_d;
    logic                 chk_waive_q, chk_waive_d;
    logic [3+SIZE_BITS:0] chk_expect_q, chk_expect_d;
    logic [3+SIZE_BITS:0] chk_actual_q, chk_actual_d;
    logic                 reuse_q, reuse_d;
    logic [SOURCE_BITS:0] count_q, count_d;

    assign a_fire = a_valid & a_ready;
    assign d_fire = d_valid & d_ready;

    tl_beat_counter #(
        .IS_D           (1'b0),
        .SIZE_BITS      (SIZE_BITS),
        .LOG_BEAT_BYTES (LOG_BEAT_BYTES),
        .MAX_LOG_BEATS  (MAX_LOG_BEATS)
    ) u_a_beats (
        .clock   (clock),
        .reset_n (reset_n),
        .fire    (a_fire),
        .opcode  (a_opcode),
        .size    (a_size),
        .first   (a_first),
        .last    (a_last)
    );

    tl_beat_counter #(
        .IS_D           (1'b1),
        .SIZE_BITS      (SIZE_BITS),
        .LOG_BEAT_BYTES (LOG_BEAT_BYTES),
        .MAX_LOG_BEATS  (MAX_LOG_BEATS)
    ) u_d_beats (
        .clock   (clock),
        .reset_n (reset_n),
        .fire    (d_fire),
        .opcode  (d_opcode),
        .size    (d_size),
        .first   (d_first),
        .last    (d_last)
    );

    // Requests register on their first A beat, responses retire on their last D beat
    assign unused_beat_flags = a_last ^ d_first;

    // Table update and check formation. The D clear is applied before the A
    // set so a source that retires and is reissued in the same cycle ends up
    // holding the new request without flagging a reuse. Cleared entries are
    // zeroed so a response with nothing in flight expects {1, 0, 0}.
    always_comb begin
        table_d      = table_q;
        d_ent        = table_q[d_source];
        chk_idle_d   = 1'b1;
        chk_waive_d  = 1'b0;
        chk_expect_d = chk_expect_q;
        chk_actual_d = chk_actual_q;
        reuse_d      = 1'b0;
        count_d      = '0;

        if (d_fire && d_last) begin
            chk_idle_d        = 1'b0;
            chk_waive_d       = d_denied;
            chk_expect_d      = {1'b1, d_ent.exp_op, d_ent.size};
            chk_actual_d      = {d_ent.valid, d_opcode, d_size};
            table_d[d_source] = '0;
        end

        if (a_fire && a_first) begin
            reuse_d                  = table_d[a_source].valid;
            table_d[a_source].valid  = 1'b1;
            table_d[a_source].exp_op = exp_op_for(a_opcode);
            table_d[a_source].size   = a_size;
        end

        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + {{SOURCE_BITS{1'b0}}, table_d[i].valid};
        end
    end

    // State and registered outputs; reset wipes everything mid-burst
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
            chk_idle_q   <= 1'b1;
            chk_waive_q  <= 1'b0;
            chk_expect_q <= '0;
            chk_actual_q <= '0;
            reuse_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            table_q      <= table_d;
            chk_idle_q   <= chk_idle_d;
            chk_waive_q  <= chk_waive_d;
            chk_expect_q <= chk_expect_d;
            chk_actual_q <= chk_actual_d;
            reuse_q      <= reuse_d;
            count_q      <= count_d;
        end
    end

    assign chk_idle         = chk_idle_q;
    assign chk_waive        = chk_waive_q;
    assign chk_expect       = chk_expect_q;
    assign chk_actual       = chk_actual_q;
    assign err_source_reuse = reuse_q;
    assign inflight_count   = count_q;

endmodule

// File: tb/tb_tl_inflight_check_gen.sv
// Testbench for tl_inflight_check_gen: directed vector table, a reset
// mid-burst sequence and randomized traffic against a transaction-level model.
module tb_tl_inflight_check_gen;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       a_valid, a_ready, d_valid, d_ready, d_denied;
    logic [2:0] a_opcode, d_opcode;
    logic [3:0] a_size, a_source, d_size, d_source;
    logic       chk_idle, chk_waive, err_source_reuse;
    logic [7:0] chk_expect, chk_actual;
    logic [4:0] inflight_count;

    int checks;
    int failures;

    // Reference model: per-source outstanding request, remaining burst beats
    bit         m_valid [16];
    logic [2:0] m_exp   [16];
    logic [3:0] m_size  [16];
    int         a_rem;
    int         d_rem;
    bit         e_idle, e_waive, e_reuse;
    logic [7:0] e_expect, e_actual;
    logic [4:0] e_count;

    typedef struct {
        bit av; logic [2:0] aop; logic [3:0] asz; logic [3:0] asrc;
        bit dv; logic [2:0] dop; logic [3:0] dsz; logic [3:0] dsrc; bit dden;
        bit idle; bit waive; logic [7:0] ex; logic [7:0] ac; bit reuse; logic [4:0] cnt;
    } vec_t;
    vec_t vecs[$];

    always #5 clock = ~clock;

    tl_inflight_check_gen dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .a_valid          (a_valid),
        .a_ready          (a_ready),
        .a_opcode         (a_opcode),
        .a_size           (a_size),
        .a_source         (a_source),
        .d_valid          (d_valid),
        .d_ready          (d_ready),
        .d_opcode         (d_opcode),
        .d_size           (d_size),
        .d_source         (d_source),
        .d_denied         (d_denied),
        .chk_idle         (chk_idle),
        .chk_waive        (chk_waive),
        .chk_expect       (chk_expect),
        .chk_actual       (chk_actual),
        .err_source_reuse (err_source_reuse),
        .inflight_count   (inflight_count)
    );

    // Beats in a burst: bytes over an 8-byte bus, at least 1, at most 8
    function automatic int n_beats(bit is_d, logic [2:0] op, logic [3:0] sz);
        bit burst;
        int n;
        burst = is_d ? (op == 3'd1) : (op == 3'd0 || op == 3'd1);
        if (!burst) return 1;
        n = (1 << sz) / 8;
        if (n < 1) n = 1;
        if (n > 8) n = 8;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_exp[i] = 3'd0; m_size[i] = 4'd0;
        end
        a_rem = 0; d_rem = 0;
        e_idle = 1; e_waive = 0; e_reuse = 0;
        e_expect = 8'h00; e_actual = 8'h00; e_count = 5'd0;
    endtask

    // Predict what the DUT registers at the coming clock edge
    task automatic model_step();
        bit a_f, d_f, a_first, d_last;
        int n;
        a_f = a_valid && a_ready;
        d_f = d_valid && d_ready;
        a_first = (a_rem == 0);
        if (a_f) begin
            if (a_rem == 0) a_rem = n_beats(0, a_opcode, a_size) - 1;
            else a_rem--;
        end
        d_last = 0;
        if (d_f) begin
            if (d_rem == 0) begin
                n = n_beats(1, d_opcode, d_size);
                d_last = (n == 1);
                d_rem = n - 1;
            end else begin
                d_last = (d_rem == 1);
                d_rem--;
            end
        end
        e_reuse = 0;
        e_idle = 1;
        e_waive = 0;
        if (d_last) begin
            e_idle   = 0;
            e_waive  = d_denied;
            e_expect = {1'b1, m_exp[d_source], m_size[d_source]};
            e_actual = {m_valid[d_source], d_opcode, d_size};
            m_valid[d_source] = 0; m_exp[d_source] = 3'd0; m_size[d_source] = 4'd0;
        end
        if (a_f && a_first) begin
            e_reuse = m_valid[a_source];
            m_valid[a_source] = 1;
            m_size[a_source]  = a_size;
            if (a_opcode == 3'd4) m_exp[a_source] = 3'd1;
            else if (a_opcode == 3'd0 || a_opcode == 3'd1) m_exp[a_source] = 3'd0;
            else m_exp[a_source] = 3'd7;
        end
        e_count = 0;
        for (int i = 0; i < 16; i++) e_count = e_count + 5'(m_valid[i]);
    endtask

    task automatic drive(bit av, logic [2:0] aop, logic [3:0] asz, logic [3:0] asrc,
                         bit dv, logic [2:0] dop, logic [3:0] dsz, logic [3:0] dsrc, bit dden);
        a_valid = av; a_ready = 1; a_opcode = aop; a_size = asz; a_source = asrc;
        d_valid = dv; d_ready = 1; d_opcode = dop; d_size = dsz; d_source = dsrc;
        d_denied = dden;
    endtask

    task automatic add_vec(bit av, logic [2:0] aop, logic [3:0] asz, logic [3:0] asrc,
                           bit dv, logic [2:0] dop, logic [3:0] dsz, logic [3:0] dsrc, bit dden,
                           bit idle, bit waive, logic [7:0] ex, logic [7:0] ac, bit reuse,
                           logic [4:0] cnt);
        vec_t v;
        v.av = av; v.aop = aop; v.asz = asz; v.asrc = asrc;
        v.dv = dv; v.dop = dop; v.dsz = dsz; v.dsrc = dsrc; v.dden = dden;
        v.idle = idle; v.waive = waive; v.ex = ex; v.ac = ac; v.reuse = reuse; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Advance one cycle with the currently driven inputs
    task automatic applyStimulus();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic cmp(string nm, string field, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=%0h required=%0h", nm, field, act, req);
        end
    endtask

    task automatic checkOutput(string nm, bit idle, bit waive, logic [7:0] ex,
                               logic [7:0] ac, bit reuse, logic [4:0] cnt);
        cmp(nm, "chk_idle", 32'(chk_idle), 32'(idle));
        cmp(nm, "chk_waive", 32'(chk_waive), 32'(waive));
        cmp(nm, "chk_expect", 32'(chk_expect), 32'(ex));
        cmp(nm, "chk_actual", 32'(chk_actual), 32'(ac));
        cmp(nm, "err_source_reuse", 32'(err_source_reuse), 32'(reuse));
        cmp(nm, "inflight_count", 32'(inflight_count), 32'(cnt));
    endtask

    task automatic check_model(string nm);
        checkOutput(nm, e_idle, e_waive, e_expect, e_actual, e_reuse, e_count);
    endtask

    // Random traffic that keeps opcode/size/source stable within a burst
    task automatic random_drive();
        int live[$];
        int pick;
        a_valid = ($urandom_range(0, 3) != 0);
        a_ready = ($urandom_range(0, 3) != 0);
        d_valid = ($urandom_range(0, 2) != 0);
        d_ready = ($urandom_range(0, 3) != 0);
        d_denied = ($urandom_range(0, 5) == 0);
        if (a_rem == 0) begin
            case ($urandom_range(0, 6))
                0, 1:    a_opcode = 3'd0;
                2:       a_opcode = 3'd1;
                6:       a_opcode = 3'd2;
                default: a_opcode = 3'd4;
            endcase
            a_size   = ($urandom_range(0, 9) == 0) ? 4'(15) : 4'($urandom_range(0, 7));
            a_source = 4'($urandom_range(0, 7));
        end
        if (d_rem == 0) begin
            for (int i = 0; i < 16; i++) if (m_valid[i]) live.push_back(i);
            if (live.size() > 0 && $urandom_range(0, 3) != 0) begin
                pick = live[$urandom_range(0, live.size() - 1)];
                d_source = 4'(pick);
                if ($urandom_range(0, 4) != 0) begin
                    d_opcode = (m_exp[pick] == 3'd1) ? 3'd1 : 3'd0;
                    d_size   = m_size[pick];
                end else begin
                    d_opcode = 3'($urandom_range(0, 1));
                    d_size   = 4'($urandom_range(0, 7));
                end
            end else begin
                d_source = 4'($urandom_range(0, 15));
                d_opcode = 3'($urandom_range(0, 1));
                d_size   = 4'($urandom_range(0, 7));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset", 1, 0, 8'h00, 8'h00, 0, 5'd0);
        reset_n = 1'b1;

        // Directed vectors: inputs for one cycle, outputs visible after that edge
        add_vec(1,4,3,3, 0,0,0,0,0, 1,0,8'h00,8'h00,0,5'd1);
        add_vec(0,0,0,0, 1,1,3,3,0, 0,0,8'h93,8'h93,0,5'd0);
        add_vec(0,0,0,0, 0,0,0,0,0, 1,0,8'h93,8'h93,0,5'd0);
        add_vec(1,0,5,5, 0,0,0,0,0, 1,0,8'h93,8'h93,0,5'd1);
        add_vec(1,0,5,5, 0,0,0,0,0, 1,0,8'h93,8'h93,0,5'd1);
        add_vec(1,0,5,5, 0,0,0,0,0, 1,0,8'h93,8'h93,0,5'd1);
        add_vec(1,0,5,5, 0,0,0,0,0, 1,0,8'h93,8'h93,0,5'd1);
        add_vec(0,0,0,0, 1,0,5,5,0, 0,0,8'h85,8'h85,0,5'd0);
        add_vec(0,0,0,0, 1,0,2,7,0, 0,0,8'h80,8'h02,0,5'd0);
        add_vec(1,4,2,2, 0,0,0,0,0, 1,0,8'h80,8'h02,0,5'd1);
        add_vec(1,4,2,2, 0,0,0,0,0, 1,0,8'h80,8'h02,1,5'd1);
        add_vec(0,0,0,0, 0,0,0,0,0, 1,0,8'h80,8'h02,0,5'd1);
        add_vec(1,4,3,4, 0,0,0,0,0, 1,0,8'h80,8'h02,0,5'd2);
        add_vec(1,4,1,4, 1,1,3,4,0, 0,0,8'h93,8'h93,0,5'd2);
        add_vec(0,0,0,0, 1,0,1,4,1, 0,1,8'h91,8'h81,0,5'd1);
        add_vec(0,0,0,0, 1,1,2,2,0, 0,0,8'h92,8'h92,0,5'd0);
        add_vec(1,4,4,1, 0,0,0,0,0, 1,0,8'h92,8'h92,0,5'd1);
        add_vec(0,0,0,0, 1,1,4,1,0, 1,0,8'h92,8'h92,0,5'd1);
        add_vec(0,0,0,0, 1,1,4,1,0, 0,0,8'h94,8'h94,0,5'd0);
        add_vec(1,2,2,6, 0,0,0,0,0, 1,0,8'h94,8'h94,0,5'd1);
        add_vec(0,0,0,0, 1,0,2,6,0, 0,0,8'hF2,8'h82,0,5'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].aop, vecs[i].asz, vecs[i].asrc,
                  vecs[i].dv, vecs[i].dop, vecs[i].dsz, vecs[i].dsrc, vecs[i].dden);
            applyStimulus();
            checkOutput($sformatf("vec%0d", i), vecs[i].idle, vecs[i].waive,
                        vecs[i].ex, vecs[i].ac, vecs[i].reuse, vecs[i].cnt);
        end

        // Reset in the middle of a D burst with three requests outstanding
        drive(1,4,6,8, 0,0,0,0,0); applyStimulus(); check_model("rst_get8");
        drive(1,4,6,9, 0,0,0,0,0); applyStimulus(); check_model("rst_get9");
        drive(1,4,6,10, 0,0,0,0,0); applyStimulus(); check_model("rst_get10");
        checkOutput("rst_three", 1, 0, 8'hF2, 8'h82, 0, 5'd3);
        drive(0,0,0,0, 1,1,6,8,0); applyStimulus(); check_model("rst_dbeat1");
        applyStimulus(); check_model("rst_dbeat2");
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset", 1, 0, 8'h00, 8'h00, 0, 5'd0);
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        checkOutput("reset_hold", 1, 0, 8'h00, 8'h00, 0, 5'd0);
        reset_n = 1'b1;
        drive(0,0,0,0, 1,0,6,9,0);
        applyStimulus();
        checkOutput("stale_d", 0, 0, 8'h80, 8'h06, 0, 5'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus();
        check_model("post_stale");

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            random_drive();
            applyStimulus();
            check_model($sformatf("rand%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
